// File: rtl/per_arb_pkg.sv
// Shared types and sizing helpers for the peripheral master arbiter.
// Default widths of the request-field struct match the top-level parameter defaults.
package per_arb_pkg;

   localparam int PER_NB_REQ = 2;
   localparam int PER_ADDR_W = 32;
   localparam int PER_DATA_W = 32;
   localparam int PER_BE_W   = PER_DATA_W / 8;

   typedef logic [$clog2(PER_NB_REQ)-1:0] req_idx_t;

   typedef struct packed {
      logic [PER_ADDR_W-1:0] add;
      logic                  wen;
      logic [PER_DATA_W-1:0] wdata;
      logic [PER_BE_W-1:0]   be;
   } per_req_t;

   // Pointer/index width that never collapses to zero bits.
   function automatic int ptr_width(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/per_arb_id_fifo.sv
// In-order FIFO of granted requester indices; head is read combinationally.
// Depth must be a power of two so the pointers wrap naturally.
module per_arb_id_fifo
   import per_arb_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   localparam int PW = ptr_width(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == (PW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      cnt_d    = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/per_master_arbiter.sv
// Round-robin arbiter with hold-until-grant lock sharing one peripheral master port.
// Define PER_ARB_PRIO0_EN to give requester 0 fixed highest priority.
module per_master_arbiter
   import per_arb_pkg::*;
#(
   parameter int NB_REQ          = PER_NB_REQ,
   parameter int ADDR_WIDTH      = PER_ADDR_W,
   parameter int DATA_WIDTH      = PER_DATA_W,
   parameter int MAX_OUTSTANDING = 4,
   localparam int BE_WIDTH       = DATA_WIDTH / 8
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NB_REQ-1:0]            slv_req_i,
   input  logic [NB_REQ*ADDR_WIDTH-1:0] slv_add_i,
   input  logic [NB_REQ-1:0]            slv_wen_i,
   input  logic [NB_REQ*DATA_WIDTH-1:0] slv_wdata_i,
   input  logic [NB_REQ*BE_WIDTH-1:0]   slv_be_i,
   output logic [NB_REQ-1:0]            slv_gnt_o,
   output logic [NB_REQ-1:0]            slv_r_valid_o,
   output logic                         slv_r_opc_o,
   output logic [DATA_WIDTH-1:0]        slv_r_rdata_o,
   output logic                         per_req_o,
   output logic [ADDR_WIDTH-1:0]        per_add_o,
   output logic                         per_wen_o,
   output logic [DATA_WIDTH-1:0]        per_wdata_o,
   output logic [BE_WIDTH-1:0]          per_be_o,
   input  logic                         per_gnt_i,
   input  logic                         per_r_valid_i,
   input  logic                         per_r_opc_i,
   input  logic [DATA_WIDTH-1:0]        per_r_rdata_i,
   output logic                         busy_o,
   output logic                         err_o
);

   localparam int IDX_W = ptr_width(NB_REQ);
   typedef logic [IDX_W-1:0] idx_t;

`ifdef PER_ARB_PRIO0_EN
   localparam bit PRIO0 = 1'b1;
`else
   localparam bit PRIO0 = 1'b0;
`endif

   idx_t     rr_ptr_q, rr_ptr_d, lock_idx_q, lock_idx_d, winner, fifo_head, ptr_inc;
   logic     lock_q, lock_d, err_q, err_d;
   logic     found, hs, pop, fifo_full, fifo_empty;
   per_req_t sel;
   int       idx;

   // A pending lock wins as long as its requester keeps req high.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      if (lock_q && slv_req_i[lock_idx_q]) begin
         winner = lock_idx_q;
         found  = 1'b1;
      end else if (PRIO0 && slv_req_i[0]) begin
         winner = '0;
         found  = 1'b1;
      end else begin
         for (int k = 0; k < NB_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NB_REQ;
            if (!found && slv_req_i[idx] && (!PRIO0 || idx != 0)) begin
               winner = idx_t'(idx);
               found  = 1'b1;
            end
         end
      end
   end

   always_comb begin
      sel.add   = slv_add_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
      sel.wen   = slv_wen_i[winner];
      sel.wdata = slv_wdata_i[winner*DATA_WIDTH +: DATA_WIDTH];
      sel.be    = slv_be_i[winner*BE_WIDTH +: BE_WIDTH];
   end

   assign per_req_o   = found && !fifo_full && !rst_i;
   assign per_add_o   = sel.add;
   assign per_wen_o   = sel.wen;
   assign per_wdata_o = sel.wdata;
   assign per_be_o    = sel.be;
   assign hs          = per_req_o && per_gnt_i;
   assign pop         = per_r_valid_i && !fifo_empty;

   assign slv_r_opc_o   = per_r_opc_i;
   assign slv_r_rdata_o = per_r_rdata_i;
   assign busy_o        = !rst_i && ((|slv_req_i) || !fifo_empty);
   assign err_o         = err_q;

   generate
      for (genvar gi = 0; gi < NB_REQ; gi++) begin : g_steer
         assign slv_gnt_o[gi]     = hs  && (winner == idx_t'(gi));
         assign slv_r_valid_o[gi] = pop && (fifo_head == idx_t'(gi));
      end
   endgenerate

   // In priority mode index 0 is outside the rotation, so the pointer skips it.
   always_comb begin
      ptr_inc  = (int'(winner) == NB_REQ - 1) ? idx_t'(PRIO0) : winner + 1'b1;
      rr_ptr_d = rr_ptr_q;
      if (hs && !(PRIO0 && winner == '0)) rr_ptr_d = ptr_inc;
      lock_d     = per_req_o && !per_gnt_i;
      lock_idx_d = winner;
      err_d      = per_r_valid_i && fifo_empty;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr_q   <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         err_q      <= 1'b0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         err_q      <= err_d;
      end
   end

   per_arb_id_fifo #(
      .WIDTH (IDX_W),
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (hs),
      .data_i  (winner),
      .pop_i   (pop),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (fifo_head)
   );

endmodule

// File: tb/tb_per_master_arbiter.sv
// Scoreboard bench for per_master_arbiter: stimulus queues expected grants,
// responses and error pulses; a negedge monitor pops and compares them.
module tb_per_master_arbiter;

   localparam int NB = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = 4;

`ifdef PER_ARB_PRIO0_EN
   localparam bit PRIO0 = 1'b1;
`else
   localparam bit PRIO0 = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_i;
   logic [NB-1:0]   slv_req_i;
   logic [NB*AW-1:0] slv_add_i;
   logic [NB-1:0]   slv_wen_i;
   logic [NB*DW-1:0] slv_wdata_i;
   logic [NB*BW-1:0] slv_be_i;
   logic [NB-1:0]   slv_gnt_o;
   logic [NB-1:0]   slv_r_valid_o;
   logic            slv_r_opc_o;
   logic [DW-1:0]   slv_r_rdata_o;
   logic            per_req_o;
   logic [AW-1:0]   per_add_o;
   logic            per_wen_o;
   logic [DW-1:0]   per_wdata_o;
   logic [BW-1:0]   per_be_o;
   logic            per_gnt_i;
   logic            per_r_valid_i;
   logic            per_r_opc_i;
   logic [DW-1:0]   per_r_rdata_i;
   logic            busy_o;
   logic            err_o;

   per_master_arbiter #(
      .NB_REQ(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(4)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .slv_req_i(slv_req_i), .slv_add_i(slv_add_i), .slv_wen_i(slv_wen_i),
      .slv_wdata_i(slv_wdata_i), .slv_be_i(slv_be_i),
      .slv_gnt_o(slv_gnt_o), .slv_r_valid_o(slv_r_valid_o),
      .slv_r_opc_o(slv_r_opc_o), .slv_r_rdata_o(slv_r_rdata_o),
      .per_req_o(per_req_o), .per_add_o(per_add_o), .per_wen_o(per_wen_o),
      .per_wdata_o(per_wdata_o), .per_be_o(per_be_o), .per_gnt_i(per_gnt_i),
      .per_r_valid_i(per_r_valid_i), .per_r_opc_i(per_r_opc_i),
      .per_r_rdata_i(per_r_rdata_i), .busy_o(busy_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          gq_idx[$];
   logic [31:0] gq_add[$];
   int          rq_idx[$];
   logic [31:0] rq_data[$];
   logic        rq_opc[$];
   int          eq_cyc[$];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every DUT output event consumes one expected entry.
   always @(negedge clk) begin
      if (!rst_i) begin
         if (slv_gnt_o != '0) begin
            if (gq_idx.size() == 0) chk("unexpected_gnt", 64'(slv_gnt_o), 64'd0);
            else begin
               int          e_idx;
               logic [31:0] e_add;
               logic [1:0]  oh;
               e_idx = gq_idx.pop_front();
               e_add = gq_add.pop_front();
               oh    = 2'b01 << e_idx;
               chk("gnt_onehot", 64'(slv_gnt_o), 64'(oh));
               chk("gnt_addr", 64'(per_add_o), 64'(e_add));
               $display("cyc %0d gnt  req=%0d addr=0x%0h", cyc, e_idx, per_add_o);
            end
         end
         if (slv_r_valid_o != '0) begin
            if (rq_idx.size() == 0) chk("unexpected_rvalid", 64'(slv_r_valid_o), 64'd0);
            else begin
               int          e_idx;
               logic [31:0] e_dat;
               logic        e_opc;
               logic [1:0]  oh;
               e_idx = rq_idx.pop_front();
               e_dat = rq_data.pop_front();
               e_opc = rq_opc.pop_front();
               oh    = 2'b01 << e_idx;
               chk("rvalid_onehot", 64'(slv_r_valid_o), 64'(oh));
               chk("rdata", 64'(slv_r_rdata_o), 64'(e_dat));
               chk("ropc", 64'(slv_r_opc_o), 64'(e_opc));
               $display("cyc %0d rsp  req=%0d data=0x%0h opc=%0d", cyc, e_idx, slv_r_rdata_o, slv_r_opc_o);
            end
         end
         if (err_o) begin
            if (eq_cyc.size() == 0) chk("unexpected_err", 64'(err_o), 64'd0);
            else begin
               int e_c;
               e_c = eq_cyc.pop_front();
               chk("err_cycle", 64'(cyc), 64'(e_c));
               $display("cyc %0d err  pulse", cyc);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input bit r, input logic [31:0] a, input bit w);
      slv_req_i[i]           = r;
      slv_add_i[i*AW +: AW]  = a;
      slv_wen_i[i]           = w;
      slv_wdata_i[i*DW +: DW] = a ^ 32'h5A5A_0000;
      slv_be_i[i*BW +: BW]   = 4'hF;
   endtask

   task automatic rsp(input bit v, input logic [31:0] d, input bit opc);
      per_r_valid_i = v;
      per_r_rdata_i = d;
      per_r_opc_i   = opc;
   endtask

   task automatic exp_gnt(input int i, input logic [31:0] a);
      gq_idx.push_back(i);
      gq_add.push_back(a);
   endtask

   task automatic exp_rsp(input int i, input logic [31:0] d, input bit opc);
      rq_idx.push_back(i);
      rq_data.push_back(d);
      rq_opc.push_back(opc);
   endtask

   initial begin
      int prev;
      rst_i = 1'b1;
      slv_req_i = '0; slv_add_i = '0; slv_wen_i = '0; slv_wdata_i = '0; slv_be_i = '0;
      per_gnt_i = 1'b0;
      rsp(1'b0, 32'h0, 1'b0);

      // Reset state
      @(negedge clk);
      chk("rst_per_req", 64'(per_req_o), 64'd0);
      chk("rst_gnt", 64'(slv_gnt_o), 64'd0);
      chk("rst_rvalid", 64'(slv_r_valid_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      step();
      rst_i = 1'b0;
      step();

      // Both requesters continuously, responses one cycle later
      prev = 0;
      for (int k = 0; k < 5; k++) begin
         if (k < 4) begin
            int e;
            set_req(0, 1'b1, 32'h100, 1'b1);
            set_req(1, 1'b1, 32'h200, 1'b1);
            per_gnt_i = 1'b1;
            e = PRIO0 ? 0 : (k % 2);
            exp_gnt(e, (e == 1) ? 32'h200 : 32'h100);
            if (k > 0) begin
               rsp(1'b1, 32'hA0 + 32'(k - 1), (k == 2));
               exp_rsp(prev, 32'hA0 + 32'(k - 1), (k == 2));
            end
            prev = e;
         end else begin
            set_req(0, 1'b0, 32'h0, 1'b0);
            set_req(1, 1'b0, 32'h0, 1'b0);
            per_gnt_i = 1'b0;
            rsp(1'b1, 32'hA3, 1'b0);
            exp_rsp(prev, 32'hA3, 1'b0);
         end
         step();
      end
      rsp(1'b0, 32'h0, 1'b0);
      step();

      // Lock: requester 1 write held while requester 0 joins
      for (int j = 0; j < 3; j++) begin
         set_req(1, 1'b1, 32'h1000, 1'b0);
         if (j >= 1) set_req(0, 1'b1, 32'h100, 1'b1);
         per_gnt_i = 1'b0;
         @(negedge clk);
         chk("lock_addr", 64'(per_add_o), 64'h1000);
         chk("lock_wen", 64'(per_wen_o), 64'd0);
         step();
      end
      per_gnt_i = 1'b1;
      exp_gnt(1, 32'h1000);
      step();
      set_req(1, 1'b0, 32'h0, 1'b0);
      exp_gnt(0, 32'h100);
      step();
      set_req(0, 1'b0, 32'h0, 1'b0);
      per_gnt_i = 1'b0;
      rsp(1'b1, 32'hB0, 1'b0);
      exp_rsp(1, 32'hB0, 1'b0);
      step();
      rsp(1'b1, 32'hB1, 1'b1);
      exp_rsp(0, 32'hB1, 1'b1);
      step();
      rsp(1'b0, 32'h0, 1'b0);
      step();

      // Flow limit: four outstanding blocks the fifth until the cycle after a pop
      set_req(0, 1'b1, 32'h300, 1'b1);
      per_gnt_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_gnt(0, 32'h300);
         step();
      end
      @(negedge clk);
      chk("full_blocks_req", 64'(per_req_o), 64'd0);
      chk("full_busy", 64'(busy_o), 64'd1);
      step();
      rsp(1'b1, 32'hC0, 1'b0);
      exp_rsp(0, 32'hC0, 1'b0);
      @(negedge clk);
      chk("full_pop_same_cycle", 64'(per_req_o), 64'd0);
      step();
      rsp(1'b0, 32'h0, 1'b0);
      exp_gnt(0, 32'h300);
      @(negedge clk);
      chk("resume_after_pop", 64'(per_req_o), 64'd1);
      step();
      set_req(0, 1'b0, 32'h0, 1'b0);
      per_gnt_i = 1'b0;
      for (int k = 1; k < 5; k++) begin
         rsp(1'b1, 32'hC0 + 32'(k), 1'b0);
         exp_rsp(0, 32'hC0 + 32'(k), 1'b0);
         step();
      end
      rsp(1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("idle_busy", 64'(busy_o), 64'd0);
      step();

      // Stray response with empty FIFO
      rsp(1'b1, 32'hDEADBEEF, 1'b0);
      eq_cyc.push_back(cyc + 1);
      @(negedge clk);
      chk("stray_no_rvalid", 64'(slv_r_valid_o), 64'd0);
      step();
      rsp(1'b0, 32'h0, 1'b0);
      step();
      step();

      // Reset with two outstanding, then a stray response
      set_req(0, 1'b1, 32'h400, 1'b1);
      per_gnt_i = 1'b1;
      exp_gnt(0, 32'h400);
      step();
      exp_gnt(0, 32'h400);
      step();
      set_req(0, 1'b0, 32'h0, 1'b0);
      per_gnt_i = 1'b0;
      @(negedge clk);
      chk("outstanding_busy", 64'(busy_o), 64'd1);
      step();
      rst_i = 1'b1;
      @(negedge clk);
      chk("midrst_per_req", 64'(per_req_o), 64'd0);
      chk("midrst_gnt", 64'(slv_gnt_o), 64'd0);
      chk("midrst_rvalid", 64'(slv_r_valid_o), 64'd0);
      chk("midrst_err", 64'(err_o), 64'd0);
      chk("midrst_busy", 64'(busy_o), 64'd0);
      step();
      rst_i = 1'b0;
      step();
      rsp(1'b1, 32'h77, 1'b0);
      eq_cyc.push_back(cyc + 1);
      @(negedge clk);
      chk("post_rst_no_rvalid", 64'(slv_r_valid_o), 64'd0);
      step();
      rsp(1'b0, 32'h0, 1'b0);
      step();
      step();

`ifdef PER_ARB_PRIO0_EN
      // Fixed priority: requester 0 always wins until it drops
      for (int k = 0; k < 5; k++) begin
         if (k < 4) begin
            set_req(0, (k < 3), 32'h500, 1'b1);
            set_req(1, 1'b1, 32'h600, 1'b1);
            per_gnt_i = 1'b1;
            exp_gnt((k < 3) ? 0 : 1, (k < 3) ? 32'h500 : 32'h600);
         end else begin
            set_req(0, 1'b0, 32'h0, 1'b0);
            set_req(1, 1'b0, 32'h0, 1'b0);
            per_gnt_i = 1'b0;
         end
         if (k > 0) begin
            rsp(1'b1, 32'hD0 + 32'(k - 1), 1'b0);
            exp_rsp((k == 4) ? 1 : 0, 32'hD0 + 32'(k - 1), 1'b0);
         end
         step();
      end
      rsp(1'b0, 32'h0, 1'b0);
      step();
`endif

      chk("gnt_queue_drained", 64'(gq_idx.size()), 64'd0);
      chk("rsp_queue_drained", 64'(rq_idx.size()), 64'd0);
      chk("err_queue_drained", 64'(eq_cyc.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
